// File: rtl/loop_uhat_mul_arb_if.sv
// Bus between the loop_uhat requester lanes, the arbiter and the shared 73x6 multiplier.
// slave = arbiter view, master = requesters plus multiplier view.
`timescale 1ns/1ps
interface loop_uhat_mul_arb_if #(
  parameter int NREQ = 2,
  parameter int A_W  = 73,
  parameter int B_W  = 6,
  parameter int P_W  = 79
);
  logic                  en;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*A_W-1:0]   req_a;
  logic [NREQ*B_W-1:0]   req_b;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [P_W-1:0]        resp_data;
  logic                  mul_ce;
  logic [A_W-1:0]        mul_din0;
  logic [B_W-1:0]        mul_din1;
  logic [P_W-1:0]        mul_dout;
  logic                  idle;
  logic [31:0]           issue_cnt;
  logic [31:0]           stall_cnt;

  modport slave (
    input  en, req_valid, req_a, req_b, resp_ready, mul_dout,
    output req_ready, resp_valid, resp_data, mul_ce, mul_din0, mul_din1,
           idle, issue_cnt, stall_cnt
  );

  modport master (
    output en, req_valid, req_a, req_b, resp_ready, mul_dout,
    input  req_ready, resp_valid, resp_data, mul_ce, mul_din0, mul_din1,
           idle, issue_cnt, stall_cnt
  );
endinterface

// File: rtl/loop_uhat_mul_arb.sv
// Round-robin arbiter and tag sequencer sharing one ce-stalled pipelined multiplier.
// Optional issue/stall statistics counters: define LOOP_UHAT_MUL_ARB_STATS_EN.
`timescale 1ns/1ps
module loop_uhat_mul_arb #(
  parameter int NREQ    = 2,
  parameter int A_W     = 73,
  parameter int B_W     = 6,
  parameter int P_W     = 79,
  parameter int MUL_LAT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  loop_uhat_mul_arb_if.slave  bus
);

  localparam logic [1:0] PTR_RST = 2'(NREQ - 1);

  logic [MUL_LAT-1:0] r_tag_vld;
  logic [1:0]         r_tag_id [MUL_LAT];
  logic [1:0]         r_ptr;

  logic               w_ce;
  logic               w_head_vld;
  logic [1:0]         w_head_id;
  logic               w_gnt_any;
  logic [1:0]         w_gnt_id;
  logic [NREQ-1:0]    w_req_ready;
  logic [NREQ-1:0]    w_resp_valid;
  logic [A_W-1:0]     w_din0;
  logic [B_W-1:0]     w_din1;
  logic [P_W-1:0]     w_prod;

  assign w_head_vld = r_tag_vld[MUL_LAT-1];
  assign w_head_id  = r_tag_id[MUL_LAT-1];

  // A product sitting at the output for a consumer that is not ready freezes everything.
  always_comb begin
    w_ce = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (w_head_vld && (w_head_id == 2'(i)) && !bus.resp_ready[i]) begin
        w_ce = 1'b0;
      end
    end
  end

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_gnt_any && (2'(i) > r_ptr) && bus.req_valid[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = 2'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_gnt_any && (2'(i) <= r_ptr) && bus.req_valid[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = 2'(i);
      end
    end
    if (!(bus.en && w_ce)) begin
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
    end
  end

  // Idle slots still feed requester 0 into the multiplier; the tag marks them invalid.
  always_comb begin
    w_din0 = bus.req_a[A_W-1:0];
    w_din1 = bus.req_b[B_W-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_any && (w_gnt_id == 2'(i))) begin
        w_din0 = bus.req_a[i*A_W +: A_W];
        w_din1 = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  always_comb begin
    w_req_ready  = '0;
    w_resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_req_ready[i]  = w_gnt_any && (w_gnt_id == 2'(i));
      w_resp_valid[i] = w_head_vld && (w_head_id == 2'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
      r_ptr     <= PTR_RST;
      for (int k = 0; k < MUL_LAT; k++) begin
        r_tag_id[k] <= '0;
      end
    end else if (w_ce) begin
      r_tag_vld   <= {r_tag_vld[MUL_LAT-2:0], w_gnt_any};
      r_tag_id[0] <= w_gnt_id;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_tag_id[k] <= r_tag_id[k-1];
      end
      if (w_gnt_any) begin
        r_ptr <= w_gnt_id;
      end
    end
  end

`ifdef LOOP_UHAT_MUL_ARB_STATS_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_gnt_any) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if (!w_ce) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign bus.issue_cnt = r_issue_cnt;
  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.issue_cnt = '0;
  assign bus.stall_cnt = '0;
`endif

  assign w_prod         = bus.mul_dout;
  assign bus.resp_data  = w_prod;
  assign bus.resp_valid = w_resp_valid;
  // Gated on the output only, so reset never reaches any flop data path.
  assign bus.req_ready  = w_req_ready & {NREQ{reset_n}};
  assign bus.mul_ce     = w_ce;
  assign bus.mul_din0   = w_din0;
  assign bus.mul_din1   = w_din1;
  assign bus.idle       = ~|r_tag_vld;

endmodule

// File: tb/tb_loop_uhat_mul_arb.sv
// Bench for loop_uhat_mul_arb: directed scenarios plus random traffic against a
// grant-order queue model; includes a behavioural ce-stalled 4-stage multiplier.
`timescale 1ns/1ps
module tb_loop_uhat_mul_arb;
  localparam int NREQ = 2, A_W = 73, B_W = 6, P_W = 79, MUL_LAT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  loop_uhat_mul_arb_if #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W)) bus();

  loop_uhat_mul_arb #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(MUL_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [A_W-1:0] op_a [NREQ];
  logic [B_W-1:0] op_b [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*A_W +: A_W] = op_a[i];
      bus.req_b[i*B_W +: B_W] = op_b[i];
    end
  end

  logic [P_W-1:0] m_pipe [MUL_LAT];
  always @(posedge clk) begin
    if (bus.mul_ce) begin
      m_pipe[0] <= P_W'(bus.mul_din0) * P_W'(bus.mul_din1);
      for (int k = 1; k < MUL_LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
  end
  assign bus.mul_dout = m_pipe[MUL_LAT-1];

  // Reference model: in-order queue of granted ops, each tagged with the count of
  // enabled multiplier cycles at its grant; it is at the output after MUL_LAT of them.
  typedef struct {
    int             id;
    logic [P_W-1:0] prod;
    int             enter;
  } ent_t;

  ent_t        q[$];
  int          last_gnt = NREQ - 1;
  int          ce_total = 0;
  logic [31:0] exp_issue = 0;
  logic [31:0] exp_stall = 0;

  function automatic logic [P_W-1:0] ref_prod(int id);
    logic [P_W-1:0] p;
    p = '0;
    for (int i = 0; i < NREQ; i++)
      if (i == id) p = P_W'(op_a[i]) * P_W'(op_b[i]);
    return p;
  endfunction

  always @(negedge clk) begin : scoreboard
    int gid, hid;
    logic out_now, hrdy, exp_ce, shake;
    logic [NREQ-1:0] exp_rv, exp_rr;
    if (!reset_n) begin
      q.delete();
      last_gnt  = NREQ - 1;
      ce_total  = 0;
      exp_issue = 0;
      exp_stall = 0;
      total += 4;
      if (bus.resp_valid !== '0) begin bad++; $display("FAIL sb_rst_resp_valid got=%b want=0", bus.resp_valid); end
      if (bus.req_ready !== '0) begin bad++; $display("FAIL sb_rst_req_ready got=%b want=0", bus.req_ready); end
      if (bus.mul_ce !== 1'b1) begin bad++; $display("FAIL sb_rst_mul_ce got=%b want=1", bus.mul_ce); end
      if (bus.idle !== 1'b1) begin bad++; $display("FAIL sb_rst_idle got=%b want=1", bus.idle); end
    end else begin
      out_now = (q.size() > 0) && ((ce_total - q[0].enter) == MUL_LAT);
      hid  = out_now ? q[0].id : -1;
      hrdy = 1'b0;
      for (int i = 0; i < NREQ; i++) if (i == hid) hrdy = bus.resp_ready[i];
      exp_ce = !(out_now && !hrdy);
      shake  = out_now && hrdy;
      gid = -1;
      if (bus.en && exp_ce)
        for (int k = 1; k <= NREQ; k++)
          for (int i = 0; i < NREQ; i++)
            if (gid < 0 && i == (last_gnt + k) % NREQ && bus.req_valid[i]) gid = i;
      for (int i = 0; i < NREQ; i++) begin
        exp_rv[i] = (i == hid);
        exp_rr[i] = (i == gid);
      end
      total += 6;
      if (bus.mul_ce !== exp_ce) begin bad++; $display("FAIL sb_mul_ce got=%b want=%b", bus.mul_ce, exp_ce); end
      if (bus.resp_valid !== exp_rv) begin bad++; $display("FAIL sb_resp_valid got=%b want=%b", bus.resp_valid, exp_rv); end
      if (bus.req_ready !== exp_rr) begin bad++; $display("FAIL sb_req_ready got=%b want=%b", bus.req_ready, exp_rr); end
      if (bus.idle !== (q.size() == 0)) begin bad++; $display("FAIL sb_idle got=%b want=%b", bus.idle, q.size() == 0); end
`ifdef LOOP_UHAT_MUL_ARB_STATS_EN
      if (bus.issue_cnt !== exp_issue) begin bad++; $display("FAIL sb_issue_cnt got=%0d want=%0d", bus.issue_cnt, exp_issue); end
      if (bus.stall_cnt !== exp_stall) begin bad++; $display("FAIL sb_stall_cnt got=%0d want=%0d", bus.stall_cnt, exp_stall); end
`else
      if (bus.issue_cnt !== 32'd0) begin bad++; $display("FAIL sb_issue_cnt got=%0d want=0", bus.issue_cnt); end
      if (bus.stall_cnt !== 32'd0) begin bad++; $display("FAIL sb_stall_cnt got=%0d want=0", bus.stall_cnt); end
`endif
      if (out_now) begin
        total++;
        if (bus.resp_data !== q[0].prod) begin bad++; $display("FAIL sb_resp_data got=%0h want=%0h", bus.resp_data, q[0].prod); end
      end
      if (shake) void'(q.pop_front());
      if (gid >= 0) begin
        q.push_back('{id: gid, prod: ref_prod(gid), enter: ce_total});
        last_gnt = gid;
        exp_issue++;
      end
      if (exp_ce) ce_total++;
      else exp_stall++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.en = 1'b1;
    bus.req_valid = 2'b11;
    bus.resp_ready = 2'b11;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
    @(negedge clk);
    total += 5;
    if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", bus.req_ready); end
    if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b want=00", bus.resp_valid); end
    if (bus.mul_ce !== 1'b1) begin bad++; $display("FAIL reset_mul_ce got=%b want=1", bus.mul_ce); end
    if (bus.idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", bus.idle); end
    if (bus.issue_cnt !== 32'd0 || bus.stall_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", bus.issue_cnt, bus.stall_cnt);
    end
    tick();
    bus.req_valid = 2'b00;
    bus.en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    bus.en = 1'b1;
    bus.resp_ready = 2'b11;
    op_a[0] = 73'd3;
    op_b[0] = 6'd5;
    bus.req_valid = 2'b01;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (c < 4) begin
        if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL single_early c=%0d got=%b want=00", c, bus.resp_valid); end
      end else begin
        if (bus.resp_valid !== 2'b01 || bus.resp_data !== 79'd15) begin
          bad++; $display("FAIL single_result got=%b/%0d want=01/15", bus.resp_valid, bus.resp_data);
        end
      end
      if (c == 1) begin
        total++;
`ifdef LOOP_UHAT_MUL_ARB_STATS_EN
        if (bus.issue_cnt !== 32'd1) begin bad++; $display("FAIL single_issue_cnt got=%0d want=1", bus.issue_cnt); end
`else
        if (bus.issue_cnt !== 32'd0) begin bad++; $display("FAIL single_issue_cnt got=%0d want=0", bus.issue_cnt); end
`endif
      end
      tick();
    end
  endtask

  // Pointer rests on 0 after the single op, so the rotation starts at requester 1.
  task automatic test_contention();
    logic [P_W-1:0] p0, p1;
    logic [NREQ-1:0] want;
    op_a[0] = A_W'({$urandom(), $urandom(), $urandom()});
    op_a[1] = A_W'({$urandom(), $urandom(), $urandom()});
    op_b[0] = B_W'($urandom());
    op_b[1] = B_W'($urandom());
    p0 = P_W'(op_a[0]) * P_W'(op_b[0]);
    p1 = P_W'(op_a[1]) * P_W'(op_b[1]);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      want = (c % 2 == 0) ? 2'b10 : 2'b01;
      total++;
      if (c < 4) begin
        if (bus.req_ready !== want) begin bad++; $display("FAIL contention_grant c=%0d got=%b want=%b", c, bus.req_ready, want); end
      end else begin
        if (bus.resp_valid !== want || bus.resp_data !== ((c % 2 == 0) ? p1 : p0)) begin
          bad++; $display("FAIL contention_result c=%0d got=%b/%0h want=%b/%0h", c, bus.resp_valid, bus.resp_data,
                          want, (c % 2 == 0) ? p1 : p0);
        end
      end
      tick();
      if (c == 3) bus.req_valid = 2'b00;
    end
  endtask

  task automatic test_backpressure();
    logic [P_W-1:0] p0, p1;
    op_a[0] = A_W'({$urandom(), $urandom(), $urandom()});
    op_a[1] = A_W'({$urandom(), $urandom(), $urandom()});
    op_b[0] = B_W'($urandom());
    op_b[1] = B_W'($urandom());
    p0 = P_W'(op_a[0]) * P_W'(op_b[0]);
    p1 = P_W'(op_a[1]) * P_W'(op_b[1]);
    for (int c = 0; c < 12; c++) begin
      case (c)
        0: begin bus.req_valid = 2'b10; bus.resp_ready = 2'b11; end
        1: begin bus.req_valid = 2'b00; bus.resp_ready = 2'b01; end
        4: bus.req_valid = 2'b01;
        7: bus.resp_ready = 2'b11;
        8: bus.req_valid = 2'b00;
        default: ;
      endcase
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        total += 3;
        if (bus.mul_ce !== 1'b0) begin bad++; $display("FAIL bp_ce c=%0d got=%b want=0", c, bus.mul_ce); end
        if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_no_grant c=%0d got=%b want=00", c, bus.req_ready); end
        if (bus.resp_valid !== 2'b10 || bus.resp_data !== p1) begin
          bad++; $display("FAIL bp_hold c=%0d got=%b/%0h want=10/%0h", c, bus.resp_valid, bus.resp_data, p1);
        end
      end
      if (c == 7) begin
        total += 3;
        if (bus.mul_ce !== 1'b1 || bus.resp_valid !== 2'b10) begin
          bad++; $display("FAIL bp_release got=%b/%b want=1/10", bus.mul_ce, bus.resp_valid);
        end
        if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL bp_accept_and_grant got=%b want=01", bus.req_ready); end
`ifdef LOOP_UHAT_MUL_ARB_STATS_EN
        if (bus.stall_cnt !== 32'd3) begin bad++; $display("FAIL bp_stall_cnt got=%0d want=3", bus.stall_cnt); end
`else
        if (bus.stall_cnt !== 32'd0) begin bad++; $display("FAIL bp_stall_cnt got=%0d want=0", bus.stall_cnt); end
`endif
      end
      if (c == 11) begin
        total++;
        if (bus.resp_valid !== 2'b01 || bus.resp_data !== p0) begin
          bad++; $display("FAIL bp_drain got=%b/%0h want=01/%0h", bus.resp_valid, bus.resp_data, p0);
        end
      end
      tick();
    end
  endtask

  task automatic test_max_width();
    logic [P_W-1:0] want;
    want = (P_W'(63) << A_W) - P_W'(63);
    op_a[0] = '1;
    op_b[0] = 6'd63;
    bus.req_valid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        total++;
        if (bus.resp_valid !== 2'b01 || bus.resp_data !== want) begin
          bad++; $display("FAIL max_width got=%b/%0h want=01/%0h", bus.resp_valid, bus.resp_data, want);
        end
      end
      tick();
      bus.req_valid = 2'b00;
    end
  endtask

  task automatic test_en_low();
    int first_idle;
    first_idle = -1;
    bus.en = 1'b1;
    bus.req_valid = 2'b11;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) bus.en = 1'b0;
      @(negedge clk);
      if (c >= 2) begin
        total++;
        if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL en_low_ready c=%0d got=%b want=00", c, bus.req_ready); end
        if (first_idle < 0 && bus.idle === 1'b1) first_idle = c;
      end
      tick();
    end
    total++;
    if (first_idle < 0 || first_idle > 6) begin
      bad++; $display("FAIL en_low_drain idle_cycle got=%0d want<=6", first_idle);
    end
    bus.req_valid = 2'b00;
    bus.en = 1'b1;
  endtask

  task automatic test_reset_midflight();
    bus.en = 1'b1;
    bus.resp_ready = 2'b11;
    bus.req_valid = 2'b11;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) reset_n = 1'b0;
      if (c == 5) begin bus.req_valid = 2'b00; reset_n = 1'b1; end
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (bus.idle !== 1'b0) begin bad++; $display("FAIL midflight_busy got=%b want=0", bus.idle); end
      end
      if (c == 3) begin
        total += 2;
        if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL midflight_resp got=%b want=00", bus.resp_valid); end
        if (bus.idle !== 1'b1) begin bad++; $display("FAIL midflight_idle got=%b want=1", bus.idle); end
      end
      if (c >= 5) begin
        total++;
        if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL midflight_stale c=%0d got=%b want=00", c, bus.resp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      bus.req_valid = NREQ'($urandom());
      for (int i = 0; i < NREQ; i++) begin
        bus.resp_ready[i] = ($urandom_range(0, 3) != 0);
        op_a[i] = A_W'({$urandom(), $urandom(), $urandom()});
        op_b[i] = B_W'($urandom());
      end
      tick();
    end
    bus.en = 1'b0;
    bus.req_valid = 2'b00;
    bus.resp_ready = 2'b11;
    for (int c = 0; c < 10; c++) tick();
    total += 2;
    if (bus.idle !== 1'b1) begin bad++; $display("FAIL random_drain_idle got=%b want=1", bus.idle); end
    if (q.size() != 0) begin bad++; $display("FAIL random_drain_pending got=%0d want=0", q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_max_width();
    test_en_low();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/loop_uhat_mul_arb.md
# loop_uhat_mul_arb

Round-robin arbiter and pipeline sequencer that shares one `loop_uhat` 73x6 unsigned pipelined multiplier (4-cycle, clock-enable-stalled) between `NREQ` requesters. It grants at most one operand pair per cycle and carries each product's requester ID down a tag pipeline matched to the multiplier depth. It returns the product to the originating requester with valid/ready, and stalls the whole multiplier via `ce` when the addressed requester is not ready. Sits between the `loop_uhat` sparse-update datapath lanes and the single shared multiplier instance.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..4.
- `A_W`, 73: operand A width (multiplier `din0`).
- `B_W`, 6: operand B width (multiplier `din1`).
- `P_W`, 79: product width (`A_W+B_W`).
- `MUL_LAT`, 4: `ce`-qualified cycles from operand capture to product at `mul_dout`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  grant enable; low blocks new grants, in-flight ops still drain.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester grant (one-hot or zero).
- `req_a`  in  NREQ*A_W  flattened A operands, requester i at `[i*A_W +: A_W]`.
- `req_b`  in  NREQ*B_W  flattened B operands.
- `resp_valid`  out  NREQ  one-hot product valid.
- `resp_ready`  in  NREQ  per-requester product accept.
- `resp_data`  out  P_W  product, broadcast (= `mul_dout`).
- `mul_ce`  out  1  multiplier clock enable.
- `mul_din0`  out  A_W  to multiplier `din0`.
- `mul_din1`  out  B_W  to multiplier `din1`.
- `mul_dout`  in  P_W  from multiplier `dout`.
- `idle`  out  1  no valid tag in flight.
- `issue_cnt`, `stall_cnt`  out  32 each  statistics (see Configuration).

## Operation
- Tag pipeline: `MUL_LAT` stages of {valid, id[1:0]}. Stage 0 pairs with the multiplier input registers; stage `MUL_LAT-1` pairs with `mul_dout`.
- Stall: `mul_ce = !(tag[L-1].valid && !resp_ready[tag[L-1].id])`. The tag pipeline shifts only when `mul_ce` is high. When `mul_ce` is low, the multiplier holds `mul_dout`.
- Output: `resp_valid[i] = tag[L-1].valid && tag[L-1].id==i`. Handshake completes on `resp_valid[i] && resp_ready[i]`.
- Grant: only when `en && mul_ce`. Round-robin starts from `ptr+1` mod NREQ and grants the first requester with `req_valid` set.
- `req_ready` is combinational from `req_valid`, `ptr`, `en` and the stall condition. It does not depend on `req_ready` itself.
- On a grant to i:
  - `mul_din0/1` are muxed from requester i.
  - `tag[0] <= {1,i}`.
  - `ptr <= i`.
- No grant with `mul_ce` high: `tag[0] <= {0,x}`. The operand mux defaults to requester 0 and the product is discarded.
- Arithmetic: the product is unsigned, full width P_W, with no truncation.
- Ordering: products return in grant order. There is no reordering and no per-requester credit. A stalled consumer blocks all requesters (head-of-line blocking by design).
- `idle` = NOR of all `tag.valid`.

## Timing
- Reset (async assert, sync release) sets:
  - all `tag.valid = 0` and `ptr = NREQ-1`, so requester 0 has first priority;
  - `req_ready = 0`, `resp_valid = 0`, `mul_ce = 1`, `idle = 1`;
  - counters to 0.
- Reset mid-operation drops all in-flight products with no response. Multiplier data registers are not reset; their contents are ignored because the tags are invalid.
- Latency: grant in cycle T gives `resp_valid` in cycle T+MUL_LAT when there are no stalls. Each stall cycle adds 1.
- Throughput: 1 product per cycle when all consumers are ready.
- Simultaneous output accept and new grant in the same cycle is allowed. A consumer that is not ready blocks a grant in that same cycle.
- `en` deasserted: `req_ready = 0` from the same cycle, and the pipeline drains normally.

## Configuration
- `LOOP_UHAT_MUL_ARB_STATS_EN` defined:
  - `issue_cnt` increments on every grant.
  - `stall_cnt` increments on every cycle with `mul_ce == 0`.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter registers are built.

## Test plan
- Single op, NREQ=2: req0 A=3, B=5 at T with all ready -> `resp_valid=2'b01`, `resp_data=15` at T+4, `issue_cnt=1`.
- Contention: req0 and req1 held valid for 4 cycles -> grants 0,1,0,1; results appear in that order on consecutive cycles from T+4.
- Backpressure: `resp_ready[1]=0` for 3 cycles while its product is at the output -> `mul_ce=0` for 3 cycles, `resp_data` held, `stall_cnt=3`, no grants; release completes in order.
- Max width: A = 2^73-1, B = 63 -> `resp_data` = (2^73-1)*63 exactly, no overflow.
- Reset mid-flight: `reset_n` low with 3 ops in flight -> `resp_valid=0`, `idle=1` immediately; no stale responses after release.
- `en` low with requests pending -> no `req_ready`; in-flight ops drain; `idle` goes to 1 within 4 cycles.
